// File: rtl/mul_sequencer.sv
// Iterative low-half multiplier for the EX stage; retires BITS_PER_CYCLE multiplier bits per cycle.
// Optional early termination on an exhausted multiplier: define MUL_EARLY_TERM_EN.
module mul_sequencer #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            stall_o,
  output logic            busy_o
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   acc, mcand, mplier, result_q;
  logic [XLEN-1:0]   partial, acc_next, mcand_next, mplier_next;
  logic [CNT_W-1:0]  cnt;
  logic              last_step;

  // Shift-and-add over the low multiplier digit; wraps naturally at XLEN bits.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
    acc_next    = acc + partial;
    mcand_next  = mcand << BITS_PER_CYCLE;
    mplier_next = mplier >> BITS_PER_CYCLE;
`ifdef MUL_EARLY_TERM_EN
    last_step   = (cnt == CNT_W'(1)) || (mplier_next == '0);
`else
    last_step   = (cnt == CNT_W'(1));
`endif
  end

  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        stall_o = start_i;
        if (start_i) state_next = BUSY;
      end
      BUSY: begin
        stall_o = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Flush wins over launch and completion alike.
    if (flush_i) begin
      state_next = IDLE;
      stall_o    = 1'b0;
      done_o     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else if (state == IDLE && start_i && !flush_i) begin
      acc    <= '0;
      mcand  <= rs1_data_i;
      mplier <= rs2_data_i;
      cnt    <= CNT_W'(STEPS);
    end else if (state == BUSY && !flush_i) begin
      acc    <= acc_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      cnt    <= cnt - CNT_W'(1);
      if (last_step) result_q <= acc_next;
    end
  end

  assign result_o = result_q;
  assign busy_o   = (state != IDLE);

endmodule
